// File: rtl/issue_scheduler_pkg.sv
// Shared defines for the issue stage: queue sizing, FU type/select encodings, MDU counter width.
package issue_scheduler_pkg;

    localparam int unsigned IQ_ADDR   = 4;
    localparam int unsigned MDU_CNT_W = 6;
    localparam int unsigned FU_TYPE_W = 2;
    localparam int unsigned FU_SEL_W  = 3;

    typedef enum logic [FU_TYPE_W-1:0] {FU_ALU, FU_MDU, FU_LSU, FU_BRU} fu_type_e;

    typedef enum logic [FU_SEL_W-1:0] {
        SEL_ALU0, SEL_ALU1, SEL_MDU, SEL_LSU, SEL_BRU
    } fu_sel_e;

    // Slot 1 ALU ops go to the second ALU; every other unit exists once.
    function automatic logic [FU_SEL_W-1:0] fu_to_sel(input logic [FU_TYPE_W-1:0] fu,
                                                      input logic second);
        logic [FU_SEL_W-1:0] sel;
        case (fu_type_e'(fu))
            FU_ALU:  sel = second ? SEL_ALU1 : SEL_ALU0;
            FU_MDU:  sel = SEL_MDU;
            FU_LSU:  sel = SEL_LSU;
            default: sel = SEL_BRU;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mdu_tracker.sv
// MDU occupancy tracker: holds the mult/div unit for MUL_LAT or DIV_LAT cycles after a start.
module mdu_tracker
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    input  logic flush,
    output logic mdu_free,
    output logic mdu_done,
    output logic mdu_busy
);

    typedef enum logic {MduIdle, MduBusy} mdu_state_e;

    // The grant cycle counts as occupancy cycle 1, hence the -1 on load.
    localparam logic [MDU_CNT_W-1:0] MulLoad = MDU_CNT_W'(MUL_LAT - 1);
    localparam logic [MDU_CNT_W-1:0] DivLoad = MDU_CNT_W'(DIV_LAT - 1);
    localparam logic [MDU_CNT_W-1:0] CntOne  = MDU_CNT_W'(1);

    mdu_state_e            state_q, state_d;
    logic [MDU_CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MduIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mdu_done = 1'b0;
        case (state_q)
            MduIdle: begin
                if (start) begin
                    state_d = MduBusy;
                    cnt_d   = is_div ? DivLoad : MulLoad;
                end
            end
            MduBusy: begin
                if (flush) begin
                    state_d = MduIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        mdu_done = 1'b1;
                        state_d  = MduIdle;
                    end
                end
            end
            default: state_d = MduIdle;
        endcase
    end

    assign mdu_free = (state_q == MduIdle);
    assign mdu_busy = (state_q == MduBusy);

endmodule

// File: rtl/issue_scheduler.sv
// Dual-slot in-order issue scheduler with MDU and LSU occupancy tracking.
// Second-slot issue is enabled by defining DUAL_ISSUE_EN.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IQ_ADDR-1:0]              iq_size,
    input  logic [1:0]                      slot_valid,
    input  logic [1:0][FU_TYPE_W-1:0]       slot_fu,
    input  logic [1:0]                      slot_is_div,
    input  logic [1:0]                      slot_ready,
    input  logic                            slot1_dep,
    input  logic                            flush,
    input  logic                            lsu_ack,
    output logic [1:0]                      grant,
    output logic [1:0]                      iq_pop_number,
    output logic [1:0][FU_SEL_W-1:0]        fu_sel,
    output logic                            mdu_busy,
    output logic                            mdu_done,
    output logic                            lsu_busy
);

    typedef enum logic {LsuIdle, LsuWait} lsu_state_e;

    lsu_state_e lsu_state_q, lsu_state_d;
    logic       mdu_free, lsu_free;
    logic       v0, free0;
    logic       mdu_claim0, mdu_claim1, mdu_start, mdu_is_div, lsu_claim;

    // An ack in the same cycle frees the LSU for a back-to-back request.
    assign lsu_free = (lsu_state_q == LsuIdle) || lsu_ack;

    always_comb begin
        v0 = slot_valid[0] && (iq_size != '0);
        case (fu_type_e'(slot_fu[0]))
            FU_MDU:  free0 = mdu_free;
            FU_LSU:  free0 = lsu_free;
            default: free0 = 1'b1;
        endcase
        grant[0] = !flush && v0 && slot_ready[0] && free0;
    end

`ifdef DUAL_ISSUE_EN
    logic v1, free1;

    // Single-instance units cannot be claimed twice in one cycle.
    always_comb begin
        v1 = slot_valid[1] && (iq_size > IQ_ADDR'(1));
        case (fu_type_e'(slot_fu[1]))
            FU_ALU:  free1 = 1'b1;
            FU_MDU:  free1 = mdu_free && (slot_fu[0] != FU_MDU);
            FU_LSU:  free1 = lsu_free && (slot_fu[0] != FU_LSU);
            default: free1 = (slot_fu[0] != FU_BRU);
        endcase
        grant[1] = grant[0] && v1 && slot_ready[1] && !slot1_dep && free1;
    end
`else
    logic unused_slot1;
    assign unused_slot1 = ^{slot_valid[1], slot_ready[1], slot1_dep};
    assign grant[1]     = 1'b0;
`endif

    assign iq_pop_number = {1'b0, grant[0]} + {1'b0, grant[1]};
    assign fu_sel[0]     = grant[0] ? fu_to_sel(slot_fu[0], 1'b0) : FU_SEL_W'(SEL_ALU0);
    assign fu_sel[1]     = grant[1] ? fu_to_sel(slot_fu[1], 1'b1) : FU_SEL_W'(SEL_ALU0);

    assign mdu_claim0 = grant[0] && (slot_fu[0] == FU_MDU);
    assign mdu_claim1 = grant[1] && (slot_fu[1] == FU_MDU);
    assign mdu_start  = mdu_claim0 || mdu_claim1;
    assign mdu_is_div = mdu_claim0 ? slot_is_div[0] : slot_is_div[1];
    assign lsu_claim  = (grant[0] && (slot_fu[0] == FU_LSU)) ||
                        (grant[1] && (slot_fu[1] == FU_LSU));

    mdu_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_tracker (
        .clk      (clk),
        .rst      (rst),
        .start    (mdu_start),
        .is_div   (mdu_is_div),
        .flush    (flush),
        .mdu_free (mdu_free),
        .mdu_done (mdu_done),
        .mdu_busy (mdu_busy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lsu_state_q <= LsuIdle;
        else      lsu_state_q <= lsu_state_d;
    end

    // Flush never cancels an outstanding access; only lsu_ack retires it.
    always_comb begin
        lsu_state_d = lsu_state_q;
        if (lsu_claim)                                lsu_state_d = LsuWait;
        else if (lsu_state_q == LsuWait && lsu_ack)   lsu_state_d = LsuIdle;
    end

    assign lsu_busy = (lsu_state_q == LsuWait);

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed scoreboard bench for issue_scheduler; expectations follow DUAL_ISSUE_EN if defined.
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

`ifdef DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif
    localparam logic [1:0] G_PAIR = DUAL ? 2'b11 : 2'b01;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [IQ_ADDR-1:0]          iq_size;
    logic [1:0]                  slot_valid;
    logic [1:0][FU_TYPE_W-1:0]   slot_fu;
    logic [1:0]                  slot_is_div;
    logic [1:0]                  slot_ready;
    logic                        slot1_dep;
    logic                        flush;
    logic                        lsu_ack;
    logic [1:0]                  grant;
    logic [1:0]                  iq_pop_number;
    logic [1:0][FU_SEL_W-1:0]    fu_sel;
    logic                        mdu_busy;
    logic                        mdu_done;
    logic                        lsu_busy;

    typedef struct {
        string      tag;
        logic [1:0] grant;
        logic [1:0] pop;
        logic [2:0] sel0;
        logic [2:0] sel1;
        logic       mb;
        logic       md;
        logic       lb;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    issue_scheduler #(
        .MUL_LAT (3),
        .DIV_LAT (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .iq_size       (iq_size),
        .slot_valid    (slot_valid),
        .slot_fu       (slot_fu),
        .slot_is_div   (slot_is_div),
        .slot_ready    (slot_ready),
        .slot1_dep     (slot1_dep),
        .flush         (flush),
        .lsu_ack       (lsu_ack),
        .grant         (grant),
        .iq_pop_number (iq_pop_number),
        .fu_sel        (fu_sel),
        .mdu_busy      (mdu_busy),
        .mdu_done      (mdu_done),
        .lsu_busy      (lsu_busy)
    );

    task automatic drive(input logic [1:0] valid, input logic [1:0] fu0, input logic [1:0] fu1,
                         input logic [1:0] div, input logic [1:0] ready, input logic dep,
                         input logic [IQ_ADDR-1:0] iq, input logic fl, input logic ack);
        slot_valid  = valid;
        slot_fu[0]  = fu0;
        slot_fu[1]  = fu1;
        slot_is_div = div;
        slot_ready  = ready;
        slot1_dep   = dep;
        iq_size     = iq;
        flush       = fl;
        lsu_ack     = ack;
    endtask

    task automatic idle_inputs();
        drive(2'b00, FU_ALU, FU_ALU, 2'b00, 2'b00, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string tag, input string field, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    // Push expectation, sample mid-cycle, then step to just after the next rising edge.
    task automatic cyc(input string tag, input logic [1:0] g, input logic [2:0] s0,
                       input logic [2:0] s1, input logic mb, input logic md, input logic lb);
        exp_t e;
        e.tag  = tag;
        e.grant = g;
        e.pop  = {1'b0, g[0]} + {1'b0, g[1]};
        e.sel0 = s0;
        e.sel1 = s1;
        e.mb   = mb;
        e.md   = md;
        e.lb   = lb;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk(e.tag, "grant", {6'd0, grant}, {6'd0, e.grant});
        chk(e.tag, "pop", {6'd0, iq_pop_number}, {6'd0, e.pop});
        if (e.grant[0]) chk(e.tag, "fu_sel0", {5'd0, fu_sel[0]}, {5'd0, e.sel0});
        if (e.grant[1]) chk(e.tag, "fu_sel1", {5'd0, fu_sel[1]}, {5'd0, e.sel1});
        chk(e.tag, "mdu_busy", {7'd0, mdu_busy}, {7'd0, e.mb});
        chk(e.tag, "mdu_done", {7'd0, mdu_done}, {7'd0, e.md});
        chk(e.tag, "lsu_busy", {7'd0, lsu_busy}, {7'd0, e.lb});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        cyc("rst_idle", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 0);
        drive(2'b01, FU_ALU, FU_ALU, 2'b00, 2'b01, 1'b0, 4'd1, 1'b0, 1'b0);
        cyc("rst_alu", 2'b01, SEL_ALU0, SEL_ALU0, 0, 0, 0);
        rst = 1'b1;

        drive(2'b11, FU_ALU, FU_ALU, 2'b00, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0);
        cyc("two_alu", G_PAIR, SEL_ALU0, SEL_ALU1, 0, 0, 0);
        iq_size = 4'd1;
        cyc("iq_one", 2'b01, SEL_ALU0, SEL_ALU0, 0, 0, 0);
        iq_size = 4'd0;
        cyc("iq_zero", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 0);
        drive(2'b11, FU_ALU, FU_ALU, 2'b00, 2'b10, 1'b0, 4'd2, 1'b0, 1'b0);
        cyc("slot0_not_ready", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 0);
        drive(2'b11, FU_ALU, FU_ALU, 2'b00, 2'b11, 1'b1, 4'd2, 1'b0, 1'b0);
        cyc("dep", 2'b01, SEL_ALU0, SEL_ALU0, 0, 0, 0);
        drive(2'b11, FU_BRU, FU_BRU, 2'b00, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0);
        cyc("bru_bru", 2'b01, SEL_BRU, SEL_ALU0, 0, 0, 0);
        drive(2'b11, FU_ALU, FU_BRU, 2'b00, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0);
        cyc("alu_bru", G_PAIR, SEL_ALU0, SEL_BRU, 0, 0, 0);

        // LSU: structural conflict, stall while waiting, back-to-back on ack
        drive(2'b11, FU_LSU, FU_LSU, 2'b00, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0);
        cyc("lsu_lsu", 2'b01, SEL_LSU, SEL_ALU0, 0, 0, 0);
        drive(2'b01, FU_LSU, FU_ALU, 2'b00, 2'b01, 1'b0, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("lsu_wait", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 1);
        lsu_ack = 1'b1;
        cyc("lsu_ack_grant", 2'b01, SEL_LSU, SEL_ALU0, 0, 0, 1);
        idle_inputs();
        cyc("lsu_still_busy", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 1);
        drive(2'b01, FU_LSU, FU_ALU, 2'b00, 2'b01, 1'b0, 4'd1, 1'b1, 1'b1);
        cyc("lsu_flush_ack", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 1);
        idle_inputs();
        cyc("lsu_idle", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 0);
        drive(2'b01, FU_LSU, FU_ALU, 2'b00, 2'b01, 1'b0, 4'd1, 1'b0, 1'b0);
        cyc("lsu_grant2", 2'b01, SEL_LSU, SEL_ALU0, 0, 0, 0);
        idle_inputs();
        flush = 1'b1;
        cyc("lsu_flush_keep", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 1);
        flush = 1'b0;
        cyc("lsu_keep", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 1);
        lsu_ack = 1'b1;
        cyc("lsu_ack_only", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 1);
        lsu_ack = 1'b0;
        cyc("lsu_released", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 0);

        // DIV occupancy with a second MDU op waiting in slot 0
        drive(2'b01, FU_MDU, FU_ALU, 2'b01, 2'b01, 1'b0, 4'd1, 1'b0, 1'b0);
        cyc("div_start", 2'b01, SEL_MDU, SEL_ALU0, 0, 0, 0);
        for (int i = 1; i <= 30; i++) cyc("div_busy", 2'b00, SEL_ALU0, SEL_ALU0, 1, 0, 0);
        cyc("div_done", 2'b00, SEL_ALU0, SEL_ALU0, 1, 1, 0);
        cyc("div_regrant", 2'b01, SEL_MDU, SEL_ALU0, 0, 0, 0);
        for (int i = 1; i <= 21; i++) cyc("div2_busy", 2'b00, SEL_ALU0, SEL_ALU0, 1, 0, 0);
        flush = 1'b1;
        cyc("div_flush", 2'b00, SEL_ALU0, SEL_ALU0, 1, 0, 0);
        idle_inputs();
        for (int i = 0; i < 12; i++) cyc("post_flush", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 0);

        // Two MULs: only one MDU, second waits out MUL_LAT
        drive(2'b11, FU_MDU, FU_MDU, 2'b00, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0);
        cyc("mul_pair", 2'b01, SEL_MDU, SEL_ALU0, 0, 0, 0);
        drive(2'b01, FU_MDU, FU_ALU, 2'b00, 2'b01, 1'b0, 4'd1, 1'b0, 1'b0);
        cyc("mul_wait", 2'b00, SEL_ALU0, SEL_ALU0, 1, 0, 0);
        cyc("mul_done", 2'b00, SEL_ALU0, SEL_ALU0, 1, 1, 0);
        cyc("mul_second", 2'b01, SEL_MDU, SEL_ALU0, 0, 0, 0);
        idle_inputs();
        rst = 1'b0;
        cyc("rst_mid_mul", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc("post_rst", 2'b00, SEL_ALU0, SEL_ALU0, 0, 0, 0);

        drive(2'b11, FU_ALU, FU_MDU, 2'b00, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0);
        cyc("alu_mdu", G_PAIR, SEL_ALU0, SEL_MDU, 0, 0, 0);
        idle_inputs();
        cyc("alu_mdu_after", 2'b00, SEL_ALU0, SEL_ALU0, DUAL, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Dual-slot issue scheduler between the issue queue head and the functional units. Each cycle it decides which of the two head entries may issue, given operand readiness from the score board, structural availability of each FU, and an intra-pair dependency. It reports the in-order pop count back to the issue queue. It also tracks the occupancy of the multi-cycle MDU (mult/div) and the single outstanding LSU request.

## Interface
Parameters:
- MUL_LAT, default 3: MDU multiply occupancy in cycles (≥2).
- DIV_LAT, default 32: MDU divide occupancy in cycles (≥2, ≤64).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- iq_size  in  IQ_ADDR  current issue-queue occupancy.
- slot_valid  in  2  head entry [i] is present.
- slot_fu  in  2×FU_TYPE  target unit per slot: FU_ALU, FU_MDU, FU_LSU, FU_BRU.
- slot_is_div  in  2  MDU op is a divide (otherwise a multiply).
- slot_ready  in  2  all source operands ready per score board.
- slot1_dep  in  1  slot 1 reads the destination of slot 0.
- flush  in  1  pipeline flush (branch mispredict/exception).
- lsu_ack  in  1  LSU has accepted the outstanding request.
- grant  out  2  slot [i] issues this cycle.
- iq_pop_number  out  2  entries to pop: 0, 1 or 2.
- fu_sel  out  2×FU_SEL  unit assigned per granted slot (ALU0/ALU1/MDU/LSU/BRU).
- mdu_busy  out  1  MDU occupied.
- mdu_done  out  1  one-cycle pulse on the last MDU occupancy cycle.
- lsu_busy  out  1  LSU request outstanding.

## Operation
- Effective validity: slot0 needs iq_size≥1; slot1 needs iq_size≥2. slot_valid is ANDed with these.
- Slot 0 is granted when it is valid, ready and its FU is free. ALU always maps to ALU0. MDU is free iff MDU FSM is IDLE. LSU is free iff LSU FSM is IDLE, or it is WAIT and lsu_ack=1. BRU is always free.
- Slot 1 is granted only when all of the following hold:
  - grant[0]=1, slot 1 is valid and ready, and slot1_dep=0.
  - Its FU is free after slot 0's claim. ALU maps to ALU1. MDU, LSU and BRU are single units, so a second claim in the same cycle fails.
- iq_pop_number = grant[0]+grant[1]. Issue is strictly in order: grant=2'b10 never occurs.
- flush=1 forces grant=0 and iq_pop_number=0 that cycle.
- MDU FSM IDLE/BUSY, counter cnt (6 bits):
  - IDLE→BUSY on an MDU grant. cnt loads MUL_LAT−1 or DIV_LAT−1.
  - In BUSY, cnt decrements each cycle. At cnt==1, mdu_done=1 and the next state is IDLE.
  - The MDU is grantable again the cycle after mdu_done.
  - flush in BUSY → IDLE, cnt=0, no mdu_done.
- LSU FSM IDLE/WAIT:
  - IDLE→WAIT on an LSU grant.
  - WAIT→IDLE on lsu_ack without a new grant. A new grant in the ack cycle keeps WAIT (back-to-back issue).
  - flush does not cancel WAIT; the in-flight access completes on lsu_ack.
- mdu_busy = (state==BUSY). lsu_busy = (state==WAIT).

## Timing
- grant, fu_sel, iq_pop_number and mdu_done are combinational from the current state and inputs. There is zero-cycle latency from request to grant.
- A state change is visible the cycle after the grant. A granted MDU op holds the MDU for exactly MUL_LAT or DIV_LAT cycles, counting the grant cycle as cycle 1.
- While rst=0: MDU IDLE, cnt=0, LSU IDLE. mdu_busy=0, lsu_busy=0, mdu_done=0.
- Grant outputs are undefined-free. They evaluate per the rules with IDLE state, and rst does not force them.
- Reset asserted mid-divide aborts the operation immediately, without producing mdu_done.

## Configuration
- DUAL_ISSUE_EN defined: two-slot behaviour as above.
- DUAL_ISSUE_EN undefined:
  - grant[1] is tied to 0 and iq_pop_number ≤1.
  - Slot-1 inputs are ignored and ALU1 is never selected.
  - All other behaviour is unchanged.

## Structure
- In the shared defines package: FU_TYPE and FU_SEL enums, and the MDU cnt width constant.
- IQ_ADDR already exists there.
- One sub-module, mdu_tracker, holds the MDU FSM and counter and outputs mdu_free/mdu_done/mdu_busy.
- The LSU FSM and grant logic stay in issue_scheduler.

## Test plan
- Two ready ALU ops, iq_size=2, slot1_dep=0 → grant=2'b11, fu_sel={ALU1,ALU0}, iq_pop_number=2.
- Slot 0 DIV granted at cycle t → mdu_busy from t+1, mdu_done pulses at t+31, and a second MDU op is granted at t+32 but not at t+31.
- Two MUL ops in one cycle → grant=2'b01, pop=1. After 3 cycles the second MUL is granted.
- Slot 0 not ready, slot 1 ready ALU → grant=2'b00, pop=0. With slot1_dep=1 and both ready → grant=2'b01.
- LSU grant, lsu_ack held low for 4 cycles with a new LSU op waiting → no grant. When lsu_ack=1 the new op is granted in the same cycle and lsu_busy stays 1.
- flush during DIV at cnt=10 → grant=0 that cycle, next cycle mdu_busy=0, and mdu_done never pulses. The rst pulse mid-MUL gives the same result.
